instr_fetch: RTL and testbench

- Instruction-fetch stage with IF/ID pipeline register for the project CPU.
- Holds the PC, drives a synchronous-read instruction memory (1-cycle read latency), and absorbs stall and branch-redirect requests.
- Presents the registered instruction and its decoded fields (opcode, rd, rs, rt) to decode.
- The 6-bit rt field output feeds sign_extend_rt directly.

---
 rtl/instr_fetch.sv | 78 +++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, drives a synchronous-read instruction memory with one cycle
// of read latency, and absorbs stall and branch-redirect requests. The
// registered instruction and its decoded fields go to decode.
//
// Handshake: there is no ready/valid pair here. if_valid marks the cycles in
// which the IF/ID register holds a real instruction. stall holds the whole
// stage. redirect wins over stall and flushes both the in-flight fetch and
// the IF/ID register.
module instr_fetch #(
    parameter int              PC_W     = 32,
    parameter int              PC_INC   = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic [3:0]      if_opcode,
    output logic [5:0]      if_rd,
    output logic [5:0]      if_rs,
    output logic [5:0]      if_rt
);

    // pc is the next address to issue. fetch_pc is the address whose data
    // is on imem_rdata. fetch_vld says whether that data is meaningful.
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_vld;

    // During a stall the memory re-reads the held fetch so that imem_rdata
    // stays valid. With no fetch in flight it simply keeps reading pc.
    always_comb begin
        imem_addr = pc;
        if (stall && fetch_vld) begin
            imem_addr = fetch_pc;
        end
    end

    // PC, fetch tracking and the IF/ID register. Priority: redirect > stall > advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            fetch_pc  <= '0;
            fetch_vld <= 1'b0;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
        end else if (redirect) begin
            // if_pc and if_instr keep their old values; they are ignored while if_valid is low.
            pc        <= redirect_pc;
            fetch_vld <= 1'b0;
            if_valid  <= 1'b0;
        end else if (!stall) begin
            pc        <= pc + PC_W'(PC_INC);
            fetch_pc  <= pc;
            fetch_vld <= 1'b1;
            if_valid  <= fetch_vld;
            if_pc     <= fetch_pc;
            if_instr  <= imem_rdata;
        end
    end

    // Decoded fields are plain slices of the registered instruction.
    always_comb begin
        if_opcode = if_instr[31:28];
        if_rd     = if_instr[27:22];
        if_rs     = if_instr[21:16];
        if_rt     = if_instr[15:10];
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: synchronous memory model, a stimulus driver with a
// stream-level reference model, and a monitor that checks the IF/ID outputs
// against the expected queue.
module tb_instr_fetch;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [3:0]  if_opcode;
    logic [5:0]  if_rd;
    logic [5:0]  if_rs;
    logic [5:0]  if_rt;

    int n_cmp  = 0;
    int n_fail = 0;

    // expected record: {valid, pc, instr}
    logic [64:0] exp_q[$];

    // reference model state: next address to issue, and whether a fetch is in flight
    logic [31:0] iss;
    logic        primed;
    logic        cur_valid;
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;

    instr_fetch #(
        .PC_W    (PC_W),
        .PC_INC  (1),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_opcode  (if_opcode),
        .if_rd      (if_rd),
        .if_rs      (if_rs),
        .if_rt      (if_rt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd3) return 32'h0000_FC00;
        if (a == 32'd4) return 32'h0000_8000;
        return 32'hA000_0000 + a;
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drop reset between edges, check the immediate reset state, then release.
    task automatic do_reset(input logic st);
        stall    = st;
        redirect = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_fields", {14'b0, if_opcode, if_rd, if_rs, if_rt}, 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        stall     = 1'b0;
        iss       = RESET_PC;
        primed    = 1'b0;
        cur_valid = 1'b0;
        cur_pc    = 32'h0;
        cur_instr = 32'h0;
    endtask

    // Apply one cycle of inputs, check the issued address, then advance the model across the edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
        stall       = st;
        redirect    = rd;
        redirect_pc = tgt;
        #1;
        chk("imem_addr", imem_addr, (st && primed) ? iss - 32'd1 : iss);
        @(posedge clk);
        if (rd) begin
            iss       = tgt;
            primed    = 1'b0;
            cur_valid = 1'b0;
        end else if (!st) begin
            if (primed) begin
                cur_valid = 1'b1;
                cur_pc    = iss - 32'd1;
                cur_instr = mem_word(iss - 32'd1);
            end else begin
                cur_valid = 1'b0;
            end
            iss    = iss + 32'd1;
            primed = 1'b1;
        end
        exp_q.push_back({cur_valid, cur_pc, cur_instr});
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("if_valid", {31'b0, if_valid}, {31'b0, e[64]});
                if (e[64]) begin
                    chk("if_pc", if_pc, e[63:32]);
                    chk("if_instr", if_instr, e[31:0]);
                    chk("if_opcode", {28'b0, if_opcode}, {28'b0, e[31:28]});
                    chk("if_rd", {26'b0, if_rd}, {26'b0, e[27:22]});
                    chk("if_rs", {26'b0, if_rs}, {26'b0, e[21:16]});
                    chk("if_rt", {26'b0, if_rt}, {26'b0, e[15:10]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        iss         = RESET_PC;
        primed      = 1'b0;
        cur_valid   = 1'b0;
        cur_pc      = 32'h0;
        cur_instr   = 32'h0;

        do_reset(1'b0);
        // startup, then through the rt-extraction words at 3 and 4, up to if_pc=5
        run(7);
        // stall for three cycles while if_pc=5, then continue 6,7,8,9
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        run(4);
        // redirect to 0x40
        step(1'b0, 1'b1, 32'h40);
        run(4);
        // redirect with stall on the same edge
        step(1'b1, 1'b1, 32'h40);
        run(4);
        // wrap through all-ones
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        run(5);
        // stall while nothing is in flight
        step(1'b0, 1'b1, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        run(3);

        // randomized mix of advance, stall and redirect
        for (int i = 0; i < 400; i++) begin
            logic        st;
            logic        rd;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
            step(st, rd, tgt);
        end

        // mid-run reset with stall held
        step(1'b0, 1'b1, 32'h0);
        run(9);
        step(1'b1, 1'b0, 32'h0);
        do_reset(1'b1);
        run(6);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
